// File: rtl/div_8by4_seq.sv
// Sequential restoring divider: 8-bit unsigned dividend X by 4-bit unsigned
// divisor Y. One quotient bit is produced per clock over eight RUN cycles.
// A zero divisor skips the iterations and reports Q=FF, R=F with div_by_zero.
module div_8by4_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] X,
  input  logic [3:0] Y,
  output logic [7:0] Q,
  output logic [3:0] R,
  output logic       busy,
  output logic       done,
  output logic       div_by_zero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  a_q, a_d;      // partial remainder; bit 5 is only the subtraction sign
  logic [7:0]  w_q, w_d;      // dividend shifting out, quotient bits shifting in
  logic [2:0]  cnt_q, cnt_d;
  logic [3:0]  y_q, y_d;      // divisor captured at start
  logic [7:0]  q_q, q_d;
  logic [3:0]  r_q, r_d;
  logic        dbz_q, dbz_d;

  // One restoring step: shift {A,W} left, trial-subtract Y from A.
  logic [5:0]  a_sh;
  logic [7:0]  w_sh;
  logic [5:0]  t_diff;

  assign a_sh   = {a_q[4:0], w_q[7]};
  assign w_sh   = {w_q[6:0], 1'b0};
  assign t_diff = a_sh - {2'b00, y_q};

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      w_q     <= '0;
      cnt_q   <= '0;
      y_q     <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      w_q     <= w_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dbz_q   <= dbz_d;
    end
  end

  // Next-state, iteration step and result capture.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    w_d     = w_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
    q_d     = q_q;
    r_d     = r_q;
    dbz_d   = dbz_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          if (Y != 4'd0) begin
            a_d     = '0;
            w_d     = X;
            y_d     = Y;
            cnt_d   = '0;
            state_d = S_RUN;
          end else begin
            // Zero divisor: report saturated values without iterating.
            q_d     = 8'hFF;
            r_d     = 4'hF;
            dbz_d   = 1'b1;
            state_d = S_DONE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_RUN: begin
        if (t_diff[5]) begin
          a_d = a_sh;
          w_d = w_sh;
        end else begin
          a_d = t_diff;
          w_d = {w_sh[7:1], 1'b1};
        end
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          // Final remainder is always below Y, so the low 4 bits hold it exactly.
          q_d     = w_d;
          r_d     = a_d[3:0];
          dbz_d   = 1'b0;
          state_d = S_DONE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign Q           = q_q;
  assign R           = r_q;
  assign div_by_zero = dbz_q;
  assign busy        = (state_q == S_RUN);
  assign done        = (state_q == S_DONE);

endmodule

// File: tb/tb_div_8by4_seq.sv
// Directed bench for div_8by4_seq: hand-computed vectors, start-during-RUN,
// back-to-back starts, mid-run reset, and a full (X,Y) sweep.
module tb_div_8by4_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] X;
  logic [3:0] Y;
  logic [7:0] Q;
  logic [3:0] R;
  logic       busy;
  logic       done;
  logic       div_by_zero;

  int checks = 0;
  int errors = 0;

  div_8by4_seq dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .X           (X),
    .Y           (Y),
    .Q           (Q),
    .R           (R),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for done after the start edge; returns edges counted from
  // the start edge and how many sampled cycles showed busy.
  task automatic wait_done(output int lat, output int nbusy);
    lat = 1;
    nbusy = 0;
    while (!done && lat < 20) begin
      if (busy) nbusy++;
      @(negedge clk);
      lat++;
    end
  endtask

  // Full handshake: pulse start, scramble inputs during RUN, check the result.
  task automatic run_div(input logic [7:0] x, input logic [3:0] y,
                         input logic [7:0] eq, input logic [3:0] er, input logic ez);
    int lat, nbusy;
    @(negedge clk);
    X = x; Y = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0; X = ~x; Y = ~y;
    wait_done(lat, nbusy);
    chk($sformatf("lat x=%0d y=%0d", x, y), lat, (y == 0) ? 1 : 9);
    chk($sformatf("busycyc x=%0d y=%0d", x, y), nbusy, (y == 0) ? 0 : 8);
    chk($sformatf("Q x=%0d y=%0d", x, y), Q, eq);
    chk($sformatf("R x=%0d y=%0d", x, y), R, er);
    chk($sformatf("dbz x=%0d y=%0d", x, y), div_by_zero, ez);
    @(negedge clk);
    chk($sformatf("donepulse x=%0d y=%0d", x, y), done, 0);
    $display("div x=%0d y=%0d -> Q=%0d R=%0d dbz=%0d lat=%0d", x, y, Q, R, div_by_zero, lat);
  endtask

  initial begin
    int lat, nbusy;
    int sweep_bad;
    rst = 1'b1; start = 1'b0; X = '0; Y = '0;
    repeat (2) @(negedge clk);
    chk("rst Q", Q, 0);
    chk("rst R", R, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst dbz", div_by_zero, 0);
    rst = 1'b0;

    // Basic vectors
    run_div(8'd200, 4'd7, 8'd28, 4'd4, 1'b0);
    run_div(8'd255, 4'd1, 8'd255, 4'd0, 1'b0);
    run_div(8'd5, 4'd9, 8'd0, 4'd5, 1'b0);
    run_div(8'd225, 4'd15, 8'd15, 4'd0, 1'b0);
    run_div(8'd100, 4'd0, 8'hFF, 4'hF, 1'b1);
    run_div(8'd9, 4'd3, 8'd3, 4'd0, 1'b0);

    // Start pulse during RUN must be ignored
    @(negedge clk);
    X = 8'd50; Y = 4'd6; start = 1'b1;
    @(negedge clk);                       // after T0
    start = 1'b0;
    @(negedge clk);                       // after T1
    @(negedge clk);                       // after T2
    X = 8'd1; Y = 4'd1; start = 1'b1;
    @(negedge clk);                       // after T3
    start = 1'b0;
    lat = 4;
    while (!done && lat < 20) begin @(negedge clk); lat++; end
    chk("ign lat", lat, 9);
    chk("ign Q", Q, 8);
    chk("ign R", R, 2);
    $display("ignore-start x=50 y=6 -> Q=%0d R=%0d lat=%0d", Q, R, lat);

    // Start held in DONE: next division begins without an IDLE cycle
    X = 8'd77; Y = 4'd5; start = 1'b1;
    @(negedge clk);
    chk("b2b busy", busy, 1);
    chk("b2b done", done, 0);
    chk("b2b Qhold", Q, 8);
    start = 1'b0;
    wait_done(lat, nbusy);
    chk("b2b lat", lat, 9);
    chk("b2b Q", Q, 15);
    chk("b2b R", R, 2);
    $display("back-to-back x=77 y=5 -> Q=%0d R=%0d lat=%0d", Q, R, lat);
    @(negedge clk);

    // Asynchronous reset in the middle of a run
    X = 8'd200; Y = 4'd7; start = 1'b1;
    @(negedge clk);                       // after T0
    start = 1'b0;
    repeat (3) @(negedge clk);            // after T3
    #2 rst = 1'b1;
    #1;
    chk("mrst busy", busy, 0);
    chk("mrst done", done, 0);
    chk("mrst Q", Q, 0);
    chk("mrst R", R, 0);
    chk("mrst dbz", div_by_zero, 0);
    $display("mid-run reset -> busy=%0d done=%0d Q=%0d R=%0d", busy, done, Q, R);
    @(negedge clk);
    rst = 1'b0;
    run_div(8'd200, 4'd7, 8'd28, 4'd4, 1'b0);

    // Exhaustive sweep
    sweep_bad = 0;
    for (int xi = 0; xi < 256; xi++) begin
      for (int yi = 0; yi < 16; yi++) begin
        logic [7:0] eq;
        logic [3:0] er;
        logic       ez;
        if (yi == 0) begin
          eq = 8'hFF; er = 4'hF; ez = 1'b1;
        end else begin
          eq = 8'(xi / yi); er = 4'(xi % yi); ez = 1'b0;
        end
        @(negedge clk);
        X = 8'(xi); Y = 4'(yi); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, nbusy);
        checks++;
        assert (Q === eq && R === er && div_by_zero === ez && lat == ((yi == 0) ? 1 : 9)) else begin
          errors++;
          sweep_bad++;
          $error("FAIL sweep x=%0d y=%0d: observed Q=%0d R=%0d dbz=%0d lat=%0d expected Q=%0d R=%0d dbz=%0d",
                 xi, yi, Q, R, div_by_zero, lat, eq, er, ez);
        end
      end
    end
    $display("sweep of 4096 pairs, bad=%0d", sweep_bad);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
